// File: rtl/leaf_out_arbiter_pkg.sv
// Shared types and helpers for the leaf output arbiter.
package leaf_out_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/leaf_out_arbiter_rr_pick.sv
// Round-robin search: first set request bit strictly after i_last, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  always_comb begin
    int c;
    c       = 0;
    o_idx   = '0;
    o_found = 1'b0;
    // k = N wraps back to i_last itself, so a lone requester can win again
    for (int k = 1; k <= N; k++) begin
      c = int'(i_last) + k;
      if (c >= N) c = c - N;
      if (!o_found && i_req[c]) begin
        o_found = 1'b1;
        o_idx   = W'(c);
      end
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter muxing NUM_REQ ap_vld/ap_ack streams onto one leaf input port.
// One dead arbitration cycle per grant; grants end on a BURST_LEN cap or a dropped valid.
module leaf_out_arbiter
  import leaf_out_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 32,
  parameter int BURST_LEN    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
  input  logic [NUM_REQ-1:0]              vld_req,
  output logic [NUM_REQ-1:0]              ack_req,
  output logic [PAYLOAD_BITS-1:0]         dout_grant,
  output logic                            vld_grant,
  input  logic                            ack_grant,
  output logic [NUM_REQ-1:0]              grant_onehot,
  output logic                            busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam int CNT_W = clog2(BURST_LEN + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] w_grant_nxt;
  logic [IDX_W-1:0] r_last_grant;
  logic [IDX_W-1:0] w_last_nxt;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_found;
  logic             w_grant_vld;
  logic             w_beat;

  rr_pick #(
    .N (NUM_REQ),
    .W (IDX_W)
  ) u_rr_pick (
    .i_req   (vld_req),
    .i_last  (r_last_grant),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_grant_vld = vld_req[r_grant_idx];
  assign w_beat      = (r_state == GRANT) && w_grant_vld && ack_grant;
  assign w_cnt_inc   = r_beat_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant_idx;
    w_last_nxt   = r_last_grant;
    w_cnt_nxt    = r_beat_cnt;
    busy         = 1'b0;
    vld_grant    = 1'b0;
    dout_grant   = '0;
    ack_req      = '0;
    grant_onehot = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = GRANT;
          w_grant_nxt = w_pick_idx;
          w_cnt_nxt   = '0;
        end
      end
      GRANT: begin
        busy                      = 1'b1;
        grant_onehot[r_grant_idx] = 1'b1;
        vld_grant                 = w_grant_vld;
        dout_grant                = din_req[r_grant_idx*PAYLOAD_BITS +: PAYLOAD_BITS];
        ack_req[r_grant_idx]      = ack_grant;
        if (w_beat) w_cnt_nxt = w_cnt_inc;
        // a stalled beat (ack low) neither counts nor ends the grant
        if (!w_grant_vld || (w_beat && (w_cnt_inc == CNT_W'(BURST_LEN)))) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_grant_idx;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant_idx  <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_idx  <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_beat_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed stimulus with a beat scoreboard: expected (requester, data, cycle) queued up front, checked by a monitor.
module tb_leaf_out_arbiter;

  logic         clk;
  logic         reset;
  logic [127:0] din_req;
  logic [3:0]   vld_req;
  logic [3:0]   ack_req;
  logic [31:0]  dout_grant;
  logic         vld_grant;
  logic         ack_grant;
  logic [3:0]   grant_onehot;
  logic         busy;

  leaf_out_arbiter #(
    .NUM_REQ      (4),
    .PAYLOAD_BITS (32),
    .BURST_LEN    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .din_req      (din_req),
    .vld_req      (vld_req),
    .ack_req      (ack_req),
    .dout_grant   (dout_grant),
    .vld_grant    (vld_grant),
    .ack_grant    (ack_grant),
    .grant_onehot (grant_onehot),
    .busy         (busy)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  oh;
    logic [31:0] dat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk;
  int          n_fail;
  int          cyc;
  int          rem[4];
  int          seq[4];
  logic [31:0] base_v[4];
  int          t0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      vld_req[i]          = (rem[i] != 0);
      din_req[i*32 +: 32] = base_v[i] + 32'(seq[i]);
    end
  endtask

  // Requester model: advance a stream only when its beat actually transferred.
  task automatic tick();
    logic [3:0] take;
    @(negedge clk);
    take = vld_req & ack_req;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (take[i]) begin
        seq[i] = seq[i] + 1;
        if (rem[i] > 0) rem[i] = rem[i] - 1;
      end
    end
    drive();
  endtask

  task automatic push(input int r, input int s, input int c);
    exp_t e;
    logic [3:0] oh;
    oh    = 4'b0001 << r;
    e.cyc = c;
    e.oh  = oh;
    e.dat = base_v[r] + 32'(s);
    exp_q.push_back(e);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n = n + 1;
    end
    check("drain_pending_beats", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    tick();
    #1;
    check("idle_after_drain_busy", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: every cycle, ack only to the granted index; every transferred beat matched in order.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("ack_outside_grant", {28'd0, ack_req & ~grant_onehot}, 32'd0);
      if (vld_grant === 1'b1 && ack_grant === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat_onehot", {28'd0, grant_onehot}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat_grant_onehot", {28'd0, grant_onehot}, {28'd0, e.oh});
          check("beat_data", dout_grant, e.dat);
          check("beat_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    ack_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rem[i]    = 0;
      seq[i]    = 0;
      base_v[i] = 32'hA000_0000 + (32'(i) << 16);
    end
    // reset with all four requesting, then fairness 0,1,2,3,0
    rem[0] = 32; rem[1] = 16; rem[2] = 16; rem[3] = 16;
    drive();
    tick(); tick(); tick();
    #1;
    check("rst_ack_req", {28'd0, ack_req}, 32'd0);
    check("rst_vld_grant", {31'd0, vld_grant}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant_onehot", {28'd0, grant_onehot}, 32'd0);
    check("rst_dout_grant", dout_grant, 32'd0);
    reset = 1'b0;
    t0 = cyc;
    for (int g = 0; g < 5; g++)
      for (int b = 0; b < 16; b++)
        push(g % 4, (g / 4) * 16 + b, t0 + 1 + 17 * g + b);
    tick();
    #1;
    check("first_grant_after_rst", {28'd0, grant_onehot}, 32'h1);
    drain(200);

    // early release by requester 1, requester 3 pending throughout
    base_v[1] = 32'h1111_0000; base_v[3] = 32'h3333_0000;
    seq[1] = 0; seq[3] = 0; rem[1] = 3; rem[3] = 4;
    drive();
    t0 = cyc;
    for (int s = 0; s < 3; s++) push(1, s, t0 + 1 + s);
    for (int s = 0; s < 4; s++) push(3, s, t0 + 6 + s);
    tick(); tick(); tick(); tick();
    #1;
    check("early_rel_busy", {31'd0, busy}, 32'd1);
    check("early_rel_onehot", {28'd0, grant_onehot}, 32'h2);
    check("early_rel_vld_grant", {31'd0, vld_grant}, 32'd0);
    tick();
    #1;
    check("early_rel_dead_busy", {31'd0, busy}, 32'd0);
    check("early_rel_dead_ack", {28'd0, ack_req}, 32'd0);
    tick();
    #1;
    check("early_rel_next_grant", {28'd0, grant_onehot}, 32'h8);
    drain(100);

    // burst cap on a lone persistent requester 2
    base_v[2] = 32'h2222_0000; seq[2] = 0; rem[2] = 32;
    drive();
    t0 = cyc;
    for (int s = 0; s < 32; s++) push(2, s, (s < 16) ? (t0 + 1 + s) : (t0 + 2 + s));
    drain(100);

    // backpressure: ack low for 5 cycles while 0xDEADBEEF is presented
    base_v[0] = 32'hDEAD_BEEF - 32'd5; seq[0] = 0; rem[0] = 20;
    drive();
    t0 = cyc;
    for (int s = 0; s < 20; s++)
      push(0, s, (s < 5) ? (t0 + 1 + s) : ((s < 16) ? (t0 + 6 + s) : (t0 + 7 + s)));
    for (int k = 0; k < 6; k++) tick();
    ack_grant = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_dout_held", dout_grant, 32'hDEAD_BEEF);
      check("bp_no_ack", {28'd0, ack_req}, 32'd0);
      check("bp_vld_grant", {31'd0, vld_grant}, 32'd1);
      tick();
    end
    ack_grant = 1'b1;
    drain(100);

    // reset mid-burst after beat 7 of requester 0
    base_v[0] = 32'h0A0A_0000; seq[0] = 0; rem[0] = -1;
    drive();
    t0 = cyc;
    for (int s = 0; s < 8; s++) push(0, s, t0 + 1 + s);
    tick(); tick(); tick();
    base_v[1] = 32'h0B0B_0000; seq[1] = 0; rem[1] = -1;
    drive();
    for (int k = 0; k < 6; k++) tick();
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ack_req", {28'd0, ack_req}, 32'd0);
    check("midrst_vld_grant", {31'd0, vld_grant}, 32'd0);
    check("midrst_dout", dout_grant, 32'd0);
    check("midrst_beats_seen", 32'(exp_q.size()), 32'd0);
    tick(); tick();
    rem[0] = 16; rem[1] = 16;
    drive();
    reset = 1'b0;
    t0 = cyc;
    for (int s = 8; s < 24; s++) push(0, s, t0 + 1 + (s - 8));
    for (int s = 0; s < 16; s++) push(1, s, t0 + 18 + s);
    tick();
    #1;
    check("midrst_regrant_req0", {28'd0, grant_onehot}, 32'h1);
    drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/leaf_out_arbiter.md
LEAF_OUT_ARBITER -- requirements
Module: leaf_out_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of user-kernel output streams sharing one leaf interface input port.
REQ-002 Parameter PAYLOAD_BITS, default 32: data width of each stream.
REQ-003 Parameter BURST_LEN, default 16: maximum beats per grant before forced re-arbitration.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 din_req  input  NUM_REQ*PAYLOAD_BITS  requester data; slice i is requester i.
REQ-007 vld_req  input  NUM_REQ  per-requester valid, ap_vld style.
REQ-008 ack_req  output  NUM_REQ  per-requester acknowledge, ap_ack style.
REQ-009 dout_grant  output  PAYLOAD_BITS  data to leaf interface din_leaf_user2interface.
REQ-010 vld_grant  output  1  valid to leaf interface vld_user2interface.
REQ-011 ack_grant  input  1  acknowledge from leaf interface ack_interface2user.
REQ-012 grant_onehot  output  NUM_REQ  currently granted requester, all-zero when none.
REQ-013 busy  output  1  high while in state GRANT.

Function
REQ-014 A beat transfers in any cycle where a valid and its matching acknowledge are both high.
REQ-015 The block has two states, IDLE and GRANT.
REQ-016 In IDLE, if any vld_req bit is high, the block registers a grant to the first requesting index in round-robin order beginning at last_grant+1 modulo NUM_REQ, and enters GRANT on the next edge.
REQ-017 In IDLE, vld_grant, ack_req and grant_onehot are all zero; a requester sees no acknowledge in the arbitration cycle.
REQ-018 In GRANT, dout_grant and vld_grant combinationally equal the granted requester's slice of din_req and vld_req bit; ack_req of the granted index combinationally equals ack_grant, and all other ack_req bits are zero.
REQ-019 Latency: a requester asserting vld_req in IDLE at cycle n sees vld_grant high at cycle n+1; arbitration costs exactly one dead cycle per grant.
REQ-020 A beat counter, width clog2(BURST_LEN+1), clears on entry to GRANT and increments on each transferred beat.
REQ-021 GRANT exits to IDLE at the edge following the beat that makes the count equal BURST_LEN.
REQ-022 GRANT exits to IDLE at the edge following any cycle in which the granted vld_req is low.
REQ-023 On every exit from GRANT, last_grant updates to the granted index.
REQ-024 Non-granted requesters hold their data and valid without acknowledge; no beat is ever dropped or duplicated.
REQ-025 With a single persistent requester, it is re-granted after the one dead cycle.
REQ-026 vld_req changes on non-granted inputs during GRANT have no effect on the current grant.

Reset
REQ-027 Asserting reset forces IDLE, last_grant = NUM_REQ-1, beat counter 0, grant_onehot 0, busy 0, vld_grant 0, ack_req 0, and dout_grant 0 whenever vld_grant is 0.
REQ-028 A reset asserted during a GRANT drops the grant immediately; the in-flight beat is not acknowledged.
REQ-029 After reset release, the first grant goes to requester 0 if requesting.

Structure
REQ-030 The state encoding and a clog2 helper function live in the shared leaf package; the parameter defaults stay local to the module.
REQ-031 The round-robin next-index search is a sub-module named rr_pick (inputs: request vector, last index; output: next index, found flag); everything else is flat.

Verification
REQ-032 Reset: hold vld_req=4'b1111 during reset -> ack_req=0, vld_grant=0; after release, grant_onehot=4'b0001 one cycle later.
REQ-033 Burst cap: requester 2 alone with continuous vld_req and ack_grant=1 -> exactly 16 beats, one dead cycle, then 16 more.
REQ-034 Fairness: all four requesting continuously, ack_grant=1 -> grant order 0,1,2,3,0, 16 beats each, 17 cycles per grant.
REQ-035 Early release: requester 1 sends 3 beats then drops vld_req -> IDLE next edge; requester 3, pending since the start, granted after one dead cycle.
REQ-036 Backpressure: ack_grant low for 5 cycles mid-burst -> din_req 0xDEADBEEF held on dout_grant, counter unchanged, no ack_req pulse.
REQ-037 Mid-burst reset: assert reset after beat 7 of requester 0 -> busy=0 and ack_req=0 immediately; after release, requester 0 regranted first.
